// File: rtl/fir_da_pkg.sv
// fir_da_pkg: shared constants, FSM encoding and LUT-build helpers for the DA FIR core
package fir_da_pkg;
   localparam int MAXB = 4096;
   localparam int DEF_TAPS = 64;
   localparam int DEF_COEF_W = 16;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   function automatic int clog2(input int n);
      int r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction
   function automatic logic [DEF_TAPS*DEF_COEF_W-1:0] default_coefs();
      logic [DEF_TAPS*DEF_COEF_W-1:0] v = '0;
      for (int t = 0; t < DEF_TAPS; t++)
         v[t*DEF_COEF_W +: DEF_COEF_W] = DEF_COEF_W'((t < DEF_TAPS / 2 ? t + 1 : DEF_TAPS - t) * 256);
      return v;
   endfunction
   localparam logic [DEF_TAPS*DEF_COEF_W-1:0] FIR_COEFS = default_coefs();
   // sum of the signed coefficients selected by the set bits of addr
   function automatic longint lut_entry(input logic [MAXB-1:0] coefs, input int coef_w, input int group, input int addr);
      longint s = 0;
      longint c;
      for (int t = 0; t < group; t++) begin
         c = longint'(coefs >> (t * coef_w)) & ((longint'(1) << coef_w) - 1);
         if (c[coef_w-1]) c -= longint'(1) << coef_w;
         if (addr[t]) s += c;
      end
      return s;
   endfunction
endpackage

// File: rtl/da_lut_group.sv
// da_lut_group: constant DA ROM returning the coefficient sum for one tap group
module da_lut_group import fir_da_pkg::*; #(
   parameter int GROUP = 8,
   parameter int COEF_W = 16,
   parameter logic [GROUP*COEF_W-1:0] COEFS = '0
) (
   input  logic [GROUP-1:0]               addr,
   output logic signed [COEF_W+GROUP-1:0] sum
);
   localparam int W = COEF_W + GROUP;
   logic signed [W-1:0] rom [2**GROUP];
   for (genvar a = 0; a < 2**GROUP; a++) begin : g_rom
      localparam longint V = lut_entry(MAXB'(COEFS), COEF_W, GROUP, a);
      assign rom[a] = V[W-1:0];
   end
   assign sum = rom[addr];
endmodule

// File: rtl/fir_da_param_core.sv
// fir_da_param_core: parametrised bit-serial distributed-arithmetic FIR with valid/ready input
module fir_da_param_core import fir_da_pkg::*; #(
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int TAPS = 64,
   parameter int GROUP = 8,
   parameter logic [TAPS*COEF_W-1:0] COEFS = FIR_COEFS,
   parameter int OUT_W = DATA_W + COEF_W + clog2(TAPS)
) (
   input  logic                    clk3,
   input  logic                    reset_n,
   input  logic                    clear,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_W-1:0]       in_data,
   output logic                    out_valid,
   output logic signed [OUT_W-1:0] out_data
);
   localparam int NG = TAPS / GROUP;
   localparam int LW = COEF_W + GROUP;
   localparam int CW = clog2(DATA_W + 1);
   state_t state, state_n;
   logic [DATA_W-1:0] taps [TAPS];
   logic [DATA_W-1:0] shreg [TAPS];
   logic [CW-1:0] b;
   logic signed [OUT_W-1:0] acc, gsum, acc_n;
   logic signed [LW-1:0] lut_out [NG];
   logic [TAPS-1:0] lsb;
   logic accept, last, flush;
   assign flush = !reset_n || clear;
   assign last = b == CW'(DATA_W - 1);
   for (genvar g = 0; g < NG; g++) begin : g_lut
      da_lut_group #(
         .GROUP(GROUP),
         .COEF_W(COEF_W),
         .COEFS(COEFS[g*GROUP*COEF_W +: GROUP*COEF_W])
      ) u_lut (
         .addr(lsb[g*GROUP +: GROUP]),
         .sum(lut_out[g])
      );
   end
   always_comb begin
      lsb = '0;
      for (int t = 0; t < TAPS; t++) lsb[t] = shreg[t][0];
   end
   // the sign bit carries negative weight in two's complement, hence the subtract on the last bit
   always_comb begin
      gsum = '0;
      for (int g = 0; g < NG; g++) gsum += OUT_W'(lut_out[g]);
      acc_n = last ? acc - (gsum <<< b) : acc + (gsum <<< b);
   end
   always_comb begin
      in_ready = state == IDLE && !flush;
      out_valid = state == DONE && !flush;
      accept = in_valid && in_ready;
      state_n = state == IDLE ? (accept ? SHIFT : IDLE) : state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
   end
   always_ff @(posedge clk3) state <= flush ? IDLE : state_n;
   always_ff @(posedge clk3) begin
      if (flush) begin
         taps <= '{default: '0};
         shreg <= '{default: '0};
         acc <= '0;
         b <= '0;
         if (!reset_n) out_data <= '0;
      end else if (accept) begin
         taps[0] <= in_data;
         shreg[0] <= in_data;
         for (int k = 1; k < TAPS; k++) begin
            taps[k] <= taps[k-1];
            shreg[k] <= taps[k-1];
         end
         acc <= '0;
         b <= '0;
      end else if (state == SHIFT) begin
         for (int k = 0; k < TAPS; k++) shreg[k] <= shreg[k] >> 1;
         acc <= acc_n;
         b <= b + 1'b1;
         if (last) out_data <= acc_n;
      end
   end
endmodule

// File: tb/tb_fir_da_param_core.sv
// tb_fir_da_param_core: scoreboard bench for the DA FIR core against a direct-form convolution model
module tb_fir_da_param_core;
   localparam int DW = 16, CWD = 16, T = 8, G = 4, OW = 35;
   localparam logic [T*CWD-1:0] CO = {16'd1, 16'd2, 16'd3, 16'd4, 16'd4, 16'd3, 16'd2, 16'd1};
   typedef struct {longint val; int cyc;} exp_t;
   int cf [T] = '{1, 2, 3, 4, 4, 3, 2, 1};
   logic clk3 = 0, reset_n = 0, clear = 0, in_valid = 0;
   logic in_ready, out_valid;
   logic [DW-1:0] in_data = '0;
   logic signed [OW-1:0] out_data;
   int checks = 0, errors = 0, cyc = 0, last_acc = -1;
   bit streaming = 0, prev_valid = 0;
   exp_t exp_q[$];
   exp_t e;
   longint got_q[$];
   longint hist [T] = '{default: 0};
   longint y;

   fir_da_param_core #(.DATA_W(DW), .COEF_W(CWD), .TAPS(T), .GROUP(G), .COEFS(CO), .OUT_W(OW)) dut (
      .clk3(clk3), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_data(out_data)
   );

   always #5 clk3 = ~clk3;
   always @(posedge clk3) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: bound expired or unexpected event (cycle %0d)", name, cyc);
   endtask

   // reference model: convolution of accepted history with coefficients
   always @(negedge clk3) begin
      if (!reset_n || clear) begin
         hist = '{default: 0};
         exp_q.delete();
      end else if (in_valid && in_ready) begin
         for (int k = T - 1; k > 0; k--) hist[k] = hist[k-1];
         hist[0] = longint'($signed(in_data));
         y = 0;
         for (int k = 0; k < T; k++) y += cf[k] * hist[k];
         exp_q.push_back(exp_t'{y, cyc});
         if (streaming && last_acc >= 0) check("accept_spacing", cyc - last_acc, 18);
         last_acc = cyc;
      end
   end

   always @(negedge clk3) begin
      if (out_valid) begin
         check("no_back_to_back", prev_valid, 0);
         check("ready_low_in_done", in_ready, 0);
         if (exp_q.size() == 0) fail("unexpected_strobe");
         else begin
            e = exp_q.pop_front();
            check("out_data", out_data, e.val);
            check("latency", cyc - e.cyc, 17);
         end
         got_q.push_back(out_data);
      end
      prev_valid = out_valid;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk3);
      #1;
   endtask

   task automatic send(input logic [DW-1:0] d);
      int w = 0;
      in_valid = 1;
      in_data = d;
      while (!in_ready && w < 200) begin
         tick(1);
         w++;
      end
      if (!in_ready) fail("send_timeout");
      tick(1);
      in_valid = 0;
      in_data = DW'($urandom);
   endtask

   task automatic drain();
      int w = 0;
      while (exp_q.size() > 0 && w < 100) begin
         tick(1);
         w++;
      end
      if (exp_q.size() > 0) fail("drain_timeout");
      tick(2);
   endtask

   task automatic impulse(input string name, input int amp);
      got_q.delete();
      send(DW'(amp));
      repeat (T) send('0);
      drain();
      check({name, "_count"}, got_q.size(), T + 1);
      if (got_q.size() == T + 1)
         for (int i = 0; i <= T; i++) check(name, got_q[i], i < T ? longint'(amp * cf[i]) : 0);
   endtask

   task automatic mid_abort(input bit use_rst);
      repeat (3) send(DW'($urandom));
      tick(7);
      if (use_rst) reset_n = 0;
      else clear = 1;
      #1;
      check("abort_in_ready", in_ready, 0);
      check("abort_out_valid", out_valid, 0);
      tick(1);
      if (use_rst) check("abort_rst_out_data", out_data, 0);
      reset_n = 1;
      clear = 0;
      #1;
      check("abort_ready_after", in_ready, 1);
      impulse(use_rst ? "impulse_after_rst" : "impulse_after_clr", 5);
   endtask

   initial begin
      tick(3);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      reset_n = 1;
      #1;
      check("post_rst_in_ready", in_ready, 1);
      impulse("impulse", 1);
      reset_n = 0;
      tick(2);
      reset_n = 1;
      tick(1);
      got_q.delete();
      send(16'h8000);
      send('0);
      drain();
      check("negfs_count", got_q.size(), 2);
      if (got_q.size() == 2) begin
         check("negfs_0", got_q[0], -32768);
         check("negfs_1", got_q[1], -65536);
      end
      got_q.delete();
      repeat (9) send(16'h7fff);
      drain();
      if (got_q.size() > 0) check("step_final", got_q[$], 655340);
      else fail("step_no_output");
      streaming = 1;
      last_acc = -1;
      in_valid = 1;
      repeat (18 * 10) begin
         in_data = DW'($urandom);
         tick(1);
      end
      in_valid = 0;
      streaming = 0;
      drain();
      mid_abort(0);
      mid_abort(1);
      repeat (40) begin
         tick($urandom_range(0, 4));
         send(DW'($urandom));
      end
      drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
endmodule
